// File: rtl/tour_cmd.sv
// Replays solved knight's-tour moves as vertical/horizontal motion commands.
// `TOUR_CMD_FANFARE_EN: horizontal half uses the fanfare opcode.
module tour_cmd #(
  parameter int NUM_MOVES = 24,
  parameter int IDX_W     = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_tour,
  input  logic             tour_done,
  input  logic [7:0]       move,
  output logic [IDX_W-1:0] indx,
  input  logic [15:0]      cmd_UART,
  input  logic             cmd_rdy_UART,
  output logic             clr_cmd_rdy_UART,
  output logic [15:0]      cmd,
  output logic             cmd_rdy,
  input  logic             clr_cmd_rdy,
  input  logic             send_resp,
  output logic [7:0]       resp
);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] WAIT_TOUR = 3'd1;
  localparam logic [2:0] CMD_V     = 3'd2;
  localparam logic [2:0] WAIT_V    = 3'd3;
  localparam logic [2:0] CMD_H     = 3'd4;
  localparam logic [2:0] WAIT_H    = 3'd5;

  localparam logic [3:0] OP_V = 4'h4;
`ifdef TOUR_CMD_FANFARE_EN
  localparam logic [3:0] OP_H = 4'h5;
`else
  localparam logic [3:0] OP_H = 4'h4;
`endif

  localparam logic [7:0] HD_N = 8'h00;
  localparam logic [7:0] HD_S = 8'h7F;
  localparam logic [7:0] HD_W = 8'h3F;
  localparam logic [7:0] HD_E = 8'hBF;

  localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_MOVES - 1);

  logic [2:0]       state_q, state_d;
  logic [IDX_W-1:0] indx_q, indx_d;
  logic [15:0]      cmd_q, cmd_d;
  logic             rdy_q, rdy_d;

  logic [7:0] hv, hh;
  logic [3:0] sv, sh;
  logic       last, passthru;

  // Lowest set bit selects the move; patterns are mutually exclusive.
  always_comb begin
    hv = HD_N;
    sv = 4'd0;
    hh = HD_W;
    sh = 4'd0;
    unique casez (move)
      8'b???????1: begin hv = HD_N; sv = 4'd2; hh = HD_W; sh = 4'd1; end
      8'b??????10: begin hv = HD_N; sv = 4'd2; hh = HD_E; sh = 4'd1; end
      8'b?????100: begin hv = HD_N; sv = 4'd1; hh = HD_W; sh = 4'd2; end
      8'b????1000: begin hv = HD_S; sv = 4'd1; hh = HD_W; sh = 4'd2; end
      8'b???10000: begin hv = HD_S; sv = 4'd2; hh = HD_W; sh = 4'd1; end
      8'b??100000: begin hv = HD_S; sv = 4'd2; hh = HD_E; sh = 4'd1; end
      8'b?1000000: begin hv = HD_S; sv = 4'd1; hh = HD_E; sh = 4'd2; end
      8'b10000000: begin hv = HD_N; sv = 4'd1; hh = HD_E; sh = 4'd2; end
      default: ;
    endcase
  end

  assign last = (indx_q == LAST);

  always_comb begin
    state_d = state_q;
    indx_d  = indx_q;
    cmd_d   = cmd_q;
    rdy_d   = rdy_q;
    unique case (state_q)
      IDLE: begin
        if (start_tour) state_d = WAIT_TOUR;
      end
      WAIT_TOUR: begin
        if (tour_done) begin
          indx_d  = '0;
          state_d = CMD_V;
        end
      end
      CMD_V: begin
        if (rdy_q) begin
          if (clr_cmd_rdy) begin
            rdy_d   = 1'b0;
            state_d = WAIT_V;
          end
        end else if (move == 8'h00) begin
          if (last) state_d = IDLE;
          else      indx_d  = indx_q + IDX_W'(1);
        end else begin
          cmd_d = {OP_V, hv, sv};
          rdy_d = 1'b1;
        end
      end
      WAIT_V: begin
        if (send_resp) state_d = CMD_H;
      end
      CMD_H: begin
        if (rdy_q) begin
          if (clr_cmd_rdy) begin
            rdy_d   = 1'b0;
            state_d = WAIT_H;
          end
        end else begin
          cmd_d = {OP_H, hh, sh};
          rdy_d = 1'b1;
        end
      end
      WAIT_H: begin
        if (send_resp) begin
          if (last) begin
            state_d = IDLE;
          end else begin
            indx_d  = indx_q + IDX_W'(1);
            state_d = CMD_V;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      indx_q  <= '0;
      cmd_q   <= '0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      indx_q  <= indx_d;
      cmd_q   <= cmd_d;
      rdy_q   <= rdy_d;
    end
  end

  assign passthru = (state_q == IDLE) || (state_q == WAIT_TOUR);

  assign indx             = indx_q;
  assign cmd              = passthru ? cmd_UART : cmd_q;
  assign cmd_rdy          = passthru ? cmd_rdy_UART : rdy_q;
  assign clr_cmd_rdy_UART = passthru ? clr_cmd_rdy : 1'b0;
  assign resp             = passthru ? 8'hA5 : 8'h5A;

endmodule

// File: tb/tb_tour_cmd.sv
// Self-checking bench for tour_cmd against a move-table reference model.
// Honours `TOUR_CMD_FANFARE_EN for the expected horizontal opcode.
module tb_tour_cmd;

  localparam int NM = 24;
  localparam int DX [8] = '{-1, 1, -2, -2, -1, 1, 2, 2};
  localparam int DY [8] = '{ 2, 2,  1, -1, -2, -2, -1, 1};
`ifdef TOUR_CMD_FANFARE_EN
  localparam logic [3:0] OPH = 4'h5;
`else
  localparam logic [3:0] OPH = 4'h4;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_tour = 1'b0;
  logic        tour_done = 1'b0;
  logic [7:0]  move;
  logic [4:0]  indx;
  logic [15:0] cmd_UART = '0;
  logic        cmd_rdy_UART = 1'b0;
  logic        clr_cmd_rdy_UART;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy = 1'b0;
  logic        send_resp = 1'b0;
  logic [7:0]  resp;

  logic [7:0] mv_arr [32];
  int n_chk = 0;
  int n_fail = 0;

  assign move = mv_arr[indx];

  tour_cmd #(.NUM_MOVES(NM), .IDX_W(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .start_tour(start_tour), .tour_done(tour_done),
    .move(move), .indx(indx),
    .cmd_UART(cmd_UART), .cmd_rdy_UART(cmd_rdy_UART),
    .clr_cmd_rdy_UART(clr_cmd_rdy_UART),
    .cmd(cmd), .cmd_rdy(cmd_rdy),
    .clr_cmd_rdy(clr_cmd_rdy), .send_resp(send_resp),
    .resp(resp)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic void ref_cmds(input logic [7:0] m,
                                   output logic [15:0] v,
                                   output logic [15:0] h,
                                   output bit z);
    int dx, dy;
    z = 1; v = '0; h = '0; dx = 0; dy = 0;
    for (int i = 7; i >= 0; i--)
      if (m[i]) begin dx = DX[i]; dy = DY[i]; z = 0; end
    if (!z) begin
      v = {4'h4, (dy > 0) ? 8'h00 : 8'h7F, 4'((dy < 0) ? -dy : dy)};
      h = {OPH, (dx < 0) ? 8'h3F : 8'hBF, 4'((dx < 0) ? -dx : dx)};
    end
  endfunction

  task automatic begin_tour;
    cmd_rdy_UART = 1'b0;
    start_tour = 1'b1; tick; start_tour = 1'b0;
    repeat ($urandom_range(0, 3)) tick;
    tour_done = 1'b1; tick; tour_done = 1'b0;
    cmd_UART = 16'hFFFF;
    cmd_rdy_UART = 1'b1;
  endtask

  task automatic do_half(input int idx, input logic [15:0] exp, input int dly);
    int k;
    k = 0;
    while (cmd_rdy !== 1'b1 && k < 40) begin tick; k++; end
    n_chk++;
    if (cmd_rdy !== 1'b1) begin
      n_fail++; $display("FAIL rdy_wait idx=%0d got=%b want=1", idx, cmd_rdy);
    end
    n_chk++;
    if (cmd !== exp) begin
      n_fail++; $display("FAIL cmd idx=%0d got=%h want=%h", idx, cmd, exp);
    end
    n_chk++;
    if (indx !== 5'(idx)) begin
      n_fail++; $display("FAIL indx got=%0d want=%0d", indx, idx);
    end
    n_chk++;
    if (resp !== 8'h5A || clr_cmd_rdy_UART !== 1'b0) begin
      n_fail++; $display("FAIL tour_mux resp=%h clrU=%b want 5a/0", resp, clr_cmd_rdy_UART);
    end
    clr_cmd_rdy = 1'b1; tick; clr_cmd_rdy = 1'b0;
    n_chk++;
    if (cmd_rdy !== 1'b0) begin
      n_fail++; $display("FAIL rdy_drop idx=%0d got=%b want=0", idx, cmd_rdy);
    end
    repeat (dly) tick;
    send_resp = 1'b1; tick; send_resp = 1'b0;
  endtask

  task automatic do_move(input int idx, input int dly);
    logic [15:0] v, h;
    bit z;
    ref_cmds(mv_arr[idx], v, h, z);
    if (!z) begin
      do_half(idx, v, dly);
      do_half(idx, h, dly);
    end
  endtask

  task automatic end_check;
    int k;
    logic [15:0] u;
    k = 0;
    while (resp !== 8'hA5 && k < 60) begin tick; k++; end
    cmd_rdy_UART = 1'b0;
    #1;
    n_chk++;
    if (resp !== 8'hA5 || indx !== 5'(NM - 1)) begin
      n_fail++; $display("FAIL tour_end resp=%h indx=%0d want a5/%0d", resp, indx, NM - 1);
    end
    u = 16'($urandom);
    cmd_UART = u; cmd_rdy_UART = 1'b1;
    #1;
    n_chk++;
    if (cmd !== u || cmd_rdy !== 1'b1) begin
      n_fail++; $display("FAIL end_pass cmd=%h rdy=%b want %h/1", cmd, cmd_rdy, u);
    end
    cmd_rdy_UART = 1'b0;
    tick;
  endtask

  task automatic test_reset;
    #2;
    n_chk++;
    if (cmd !== 16'h0000 || cmd_rdy !== 1'b0 || indx !== 5'd0 ||
        resp !== 8'hA5 || clr_cmd_rdy_UART !== 1'b0) begin
      n_fail++;
      $display("FAIL reset cmd=%h rdy=%b indx=%0d resp=%h clrU=%b",
               cmd, cmd_rdy, indx, resp, clr_cmd_rdy_UART);
    end
    #5 rst_n = 1'b1;
    tick;
  endtask

  task automatic test_passthrough;
    cmd_UART = 16'h4011; cmd_rdy_UART = 1'b1; clr_cmd_rdy = 1'b1;
    #1;
    n_chk++;
    if (cmd !== 16'h4011 || cmd_rdy !== 1'b1 ||
        clr_cmd_rdy_UART !== 1'b1 || resp !== 8'hA5) begin
      n_fail++;
      $display("FAIL pass cmd=%h rdy=%b clrU=%b resp=%h", cmd, cmd_rdy, clr_cmd_rdy_UART, resp);
    end
    tick;
    clr_cmd_rdy = 1'b0; cmd_rdy_UART = 1'b0;
    tour_done = 1'b1; tick; tour_done = 1'b0;
    cmd_UART = 16'h1234;
    #1;
    n_chk++;
    if (cmd !== 16'h1234 || resp !== 8'hA5) begin
      n_fail++; $display("FAIL stray_done cmd=%h resp=%h want 1234/a5", cmd, resp);
    end
  endtask

  task automatic test_single_move;
    for (int i = 0; i < 32; i++) mv_arr[i] = 8'h00;
    mv_arr[0] = 8'h02;
    begin_tour;
    do_half(0, 16'h4002, 1);
    do_half(0, {OPH, 12'hBF1}, 1);
    end_check;
  endtask

  task automatic test_full_tour;
    for (int i = 0; i < 32; i++) mv_arr[i] = (i < NM) ? 8'h40 : 8'h00;
    begin_tour;
    for (int i = 0; i < NM; i++) do_move(i, 0);
    end_check;
  endtask

  task automatic test_skip_multihot;
    for (int i = 0; i < 32; i++) mv_arr[i] = (i < NM) ? 8'h80 : 8'h00;
    mv_arr[3] = 8'h00;
    mv_arr[4] = 8'h30;
    begin_tour;
    for (int i = 0; i < 3; i++) do_move(i, 1);
    n_chk++;
    if (indx !== 5'd3 || cmd_rdy !== 1'b0) begin
      n_fail++; $display("FAIL skip_pre indx=%0d rdy=%b want 3/0", indx, cmd_rdy);
    end
    tick;
    n_chk++;
    if (indx !== 5'd4) begin
      n_fail++; $display("FAIL skip_adv indx=%0d want 4", indx);
    end
    do_half(4, 16'h47F2, 0);
    do_half(4, {OPH, 12'h3F1}, 0);
    for (int i = 5; i < NM; i++) do_move(i, 0);
    end_check;
  endtask

  task automatic test_random_tours;
    for (int t = 0; t < 3; t++) begin
      for (int i = 0; i < 32; i++) begin
        mv_arr[i] = 8'($urandom_range(0, 255));
        if ($urandom_range(0, 4) == 0 || i >= NM) mv_arr[i] = 8'h00;
      end
      begin_tour;
      for (int i = 0; i < NM; i++) do_move(i, $urandom_range(0, 3));
      end_check;
    end
  endtask

  task automatic test_stall;
    logic [15:0] v, h, c0;
    bit z, bad;
    int k;
    for (int i = 0; i < 32; i++) mv_arr[i] = (i < NM) ? 8'($urandom_range(1, 255)) : 8'h00;
    ref_cmds(mv_arr[0], v, h, z);
    begin_tour;
    k = 0;
    while (cmd_rdy !== 1'b1 && k < 40) begin tick; k++; end
    c0 = cmd;
    n_chk++;
    if (c0 !== v) begin
      n_fail++; $display("FAIL stall_cmd got=%h want=%h", c0, v);
    end
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      tick;
      if (cmd_rdy !== 1'b1 || cmd !== c0) bad = 1;
    end
    n_chk++;
    if (bad) begin
      n_fail++; $display("FAIL stall_hold rdy=%b cmd=%h want 1/%h", cmd_rdy, cmd, c0);
    end
    send_resp = 1'b1; tick; send_resp = 1'b0;
    n_chk++;
    if (cmd_rdy !== 1'b1 || cmd !== c0) begin
      n_fail++; $display("FAIL early_resp rdy=%b cmd=%h want 1/%h", cmd_rdy, cmd, c0);
    end
    clr_cmd_rdy = 1'b1; send_resp = 1'b1; tick;
    clr_cmd_rdy = 1'b0; send_resp = 1'b0;
    repeat (3) tick;
    n_chk++;
    if (cmd_rdy !== 1'b0 || resp !== 8'h5A) begin
      n_fail++; $display("FAIL simul_clr_resp rdy=%b resp=%h want 0/5a", cmd_rdy, resp);
    end
    send_resp = 1'b1; tick; send_resp = 1'b0;
    do_half(0, h, 0);
    for (int i = 1; i < NM; i++) do_move(i, 0);
    end_check;
  endtask

  task automatic test_reset_mid_tour;
    logic [15:0] v, h;
    bit z;
    for (int i = 0; i < 32; i++) mv_arr[i] = (i < NM) ? 8'($urandom_range(1, 255)) : 8'h00;
    begin_tour;
    for (int i = 0; i < 10; i++) do_move(i, 0);
    ref_cmds(mv_arr[10], v, h, z);
    do_half(10, v, 0);
    k_half(h);
    cmd_rdy_UART = 1'b0;
    rst_n = 1'b0;
    #2;
    n_chk++;
    if (cmd_rdy !== 1'b0 || indx !== 5'd0 || resp !== 8'hA5) begin
      n_fail++; $display("FAIL mid_reset rdy=%b indx=%0d resp=%h want 0/0/a5", cmd_rdy, indx, resp);
    end
    rst_n = 1'b1;
    tick;
    cmd_UART = 16'h4011; cmd_rdy_UART = 1'b1;
    #1;
    n_chk++;
    if (cmd !== 16'h4011 || cmd_rdy !== 1'b1 || resp !== 8'hA5) begin
      n_fail++; $display("FAIL post_reset_pass cmd=%h rdy=%b resp=%h", cmd, cmd_rdy, resp);
    end
    cmd_rdy_UART = 1'b0;
    tick;
  endtask

  // Issue and accept one half without sending the response (leaves WAIT state).
  task automatic k_half(input logic [15:0] exp);
    int k;
    k = 0;
    while (cmd_rdy !== 1'b1 && k < 40) begin tick; k++; end
    n_chk++;
    if (cmd !== exp || cmd_rdy !== 1'b1) begin
      n_fail++; $display("FAIL h_half cmd=%h rdy=%b want %h/1", cmd, cmd_rdy, exp);
    end
    clr_cmd_rdy = 1'b1; tick; clr_cmd_rdy = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mv_arr[i] = 8'h00;
    test_reset;
    test_passthrough;
    test_single_move;
    test_full_tour;
    test_skip_multihot;
    test_stall;
    test_random_tours;
    test_reset_mid_tour;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
